// File: rtl/approx_mac_pkg.sv
// Shared widths, signed types and saturation limits for the approximate MAC accumulator.
// Latency: n/a (package only).
// Backpressure: n/a.
package approx_mac_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W_DEF  = 8;

    typedef logic signed [PROD_W_DEF-1:0] prod_t;
    typedef logic signed [ACC_W_DEF-1:0]  acc_t;

    // Saturation limits at the default accumulator width
    localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // Sign-extend a product to accumulator width
    function automatic acc_t sext(input prod_t p);
        return acc_t'(p);
    endfunction

endpackage

// File: rtl/approx_mac_add.sv
// Signed ACC_W adder with two's-complement overflow detect; clamps when MAC_SAT_EN is defined.
// Latency: combinational.
// Backpressure: none (pure datapath); hold freezes the sum at a once a window has saturated.
module approx_mac_add
    import approx_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    input  logic                    hold,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    logic signed [ACC_W-1:0] raw;

    assign raw = a + b;
    // Overflow: operands share a sign but the truncated result does not
    assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Clamp toward the operand sign on overflow; stay pinned once the window has saturated
    always_comb begin
        sum = raw;
        if (hold) begin
            sum = a;
        end else if (ovf) begin
            sum = a[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign sum         = raw;
`endif

endmodule

// File: rtl/approx_mac_accum.sv
// Accumulates one signed product per beat into a window sum closed by in_last (build option MAC_SAT_EN).
// Latency: result registered one edge after the last beat's s1 capture; 1 beat/cycle, no bubble between windows.
// Backpressure: a pending unaccepted result stalls s1/acc and drops in_ready; clr also drops in_ready.
module approx_mac_accum
    import approx_mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]         out_cnt,
    output logic                     out_ovf
);

    if (ACC_W < PROD_W) begin : g_width_err
        $error("approx_mac_accum: ACC_W must be >= PROD_W");
    end

    logic                    rdy_en;
    logic                    adv;
    logic                    accept;
    logic                    step;
    logic                    s1_valid;
    logic                    s1_last;
    logic signed [PROD_W-1:0] s1_prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    ovf;
    logic                    add_ovf;
    logic                    ovf_inc;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~clr & rdy_en;
    assign accept   = in_valid & in_ready;
    assign step     = s1_valid & adv;
    assign prod_ext = ACC_W'(s1_prod);
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign ovf_inc  = ovf | add_ovf;

    approx_mac_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a    (acc),
        .b    (prod_ext),
        .hold (ovf),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    // Keep in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Stage 1: capture accepted beat; bubble when advancing without one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= in_last;
                s1_prod <= in_prod;
            end
        end
    end

    // Stage 2: accumulate; a last beat restarts the window for the next beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr || (step && s1_last)) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (step) begin
            acc <= sum;
            cnt <= cnt_inc;
            ovf <= ovf_inc;
        end
    end

    // Output register: load on a closing beat, drop on consumer accept, clr wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (step && s1_last) begin
            out_valid <= 1'b1;
            out_data  <= sum;
            out_cnt   <= cnt_inc;
            out_ovf   <= ovf_inc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_approx_mac_accum.sv
// Directed self-checking bench for approx_mac_accum at ACC_W=16 (honours MAC_SAT_EN).
// Latency: n/a.
// Backpressure: exercised by holding out_ready low with a result pending.
module tb_approx_mac_accum;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     clr;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [PROD_W-1:0] in_prod;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]         out_cnt;
    logic                     out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    approx_mac_accum #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic signed [PROD_W-1:0] p, input logic l);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic signed [31:0] d,
                                input logic signed [31:0] c, input logic signed [31:0] o);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_data"}, 32'(out_data), d);
        check({tag, "_cnt"}, 32'(out_cnt), c);
        check({tag, "_ovf"}, 32'(out_ovf), o);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_cnt", 32'(out_cnt), 0);
        check("rst_ovf", 32'(out_ovf), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", 32'(in_ready), 0);
        tick();
        check("rel_in_ready", 32'(in_ready), 1);

        // Basic window: 100 - 50 + 16384
        out_ready = 1'b1;
        beat(16'sd100, 1'b0);
        beat(-16'sd50, 1'b0);
        beat(16'sd16384, 1'b1);
        check("w1_not_yet", 32'(out_valid), 0);
        tick();
        check_result("w1", 16434, 3, 0);
        tick();
        check("w1_one_wide", 32'(out_valid), 0);

        // Backpressure: result 1+2 held while out_ready low
        out_ready = 1'b0;
        beat(16'sd1, 1'b0);
        beat(16'sd2, 1'b1);
        tick();
        check_result("bp", 3, 2, 0);
        in_valid = 1'b1;
        in_prod  = 16'sd7;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", 32'(in_ready), 0);
            tick();
            check("bp_stable_valid", 32'(out_valid), 1);
            check("bp_stable_data", 32'(out_data), 3);
            check("bp_stable_cnt", 32'(out_cnt), 2);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_resume", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_drained", 32'(out_valid), 0);
        tick();
        check_result("bp_next", 7, 1, 0);
        tick();

        // Overflow: 16384 + 16384 at 16-bit accumulator
        beat(16'sd16384, 1'b0);
        beat(16'sd16384, 1'b1);
        tick();
`ifdef MAC_SAT_EN
        check_result("ovf_sat", 32767, 2, 1);
`else
        check_result("ovf_wrap", -32768, 2, 1);
`endif
        tick();

        // Next window after overflow must start clean
        beat(16'sd4, 1'b1);
        tick();
        check_result("post_ovf", 4, 1, 0);
        tick();

        // clr flushes 10/20 window; beat presented with clr is refused
        beat(16'sd10, 1'b0);
        beat(16'sd20, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 16'sd99;
        in_last  = 1'b1;
        #1;
        check("clr_in_ready", 32'(in_ready), 0);
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("clr_no_out", 32'(out_valid), 0);
        tick();
        check("clr_no_out2", 32'(out_valid), 0);
        beat(16'sd5, 1'b1);
        tick();
        check_result("clr_next", 5, 1, 0);
        tick();

        // Back-to-back windows [3(last)][-16256, 7(last)]
        in_valid = 1'b1;
        in_prod  = 16'sd3;
        in_last  = 1'b1;
        tick();
        in_prod  = -16'sd16256;
        in_last  = 1'b0;
        check("b2b_ready1", 32'(in_ready), 1);
        tick();
        check_result("b2b_w1", 3, 1, 0);
        in_prod  = 16'sd7;
        in_last  = 1'b1;
        check("b2b_ready2", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("b2b_gap", 32'(out_valid), 0);
        tick();
        check_result("b2b_w2", -16249, 2, 0);

        // Asynchronous reset while a result is valid
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_data", 32'(out_data), 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
